ctxt_char_collector: RTL and testbench
======================================

Name: ctxt_char_collector

Overview:
- Downstream stage of the two-key Caesar cipher core: consumes the registered `ctxt_char`/`ctx_ready` stream and the cipher error flags.
- Buffers accepted cipher characters in a FIFO and drains them over a valid/ready interface to a byte sink (UART TX / host port).
- Frames messages: `msg_start` opens a message, `msg_end` closes it by appending a terminator character.
- Counts rejected characters per message.

Parameters:
- DEPTH, 16, FIFO entries; power of two, ≥2.
- ERR_CNT_W, 8, error counter width.
- TERM_CHAR, 8'h00, terminator pushed at end of message.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- msg_start  input  1  pulse: open message, clear per-message status
- msg_end  input  1  pulse: close message
- ptxt_valid_q  input  1  cipher's ptxt_valid delayed one cycle, aligned with cipher outputs
- ctx_ready  input  1  cipher output valid
- ctxt_char  input  8  cipher output character
- err_invalid_key_shift_num  input  1  cipher key error flag
- err_invalid_ptxt_char  input  1  cipher char error flag
- out_valid  output  1  FIFO head valid
- out_char  output  8  FIFO head data
- out_ready  input  1  sink accepts
- fifo_count  output  $clog2(DEPTH)+1  occupancy
- overflow  output  1  sticky: character dropped this message
- err_count  output  ERR_CNT_W  rejected characters this message, saturating
- busy  output  1  state != IDLE
- msg_done  output  1  one-cycle pulse when terminator is pushed

Behaviour:
- Reset (async assert, sync release):
  - State IDLE.
  - FIFO pointers and `fifo_count` 0; `out_valid` 0; `out_char` 8'h00.
  - `overflow`, `err_count`, `busy`, `msg_done` all 0.
- States:
  - IDLE: input stream ignored. `msg_start` → COLLECT and clears `overflow` and `err_count`.
  - COLLECT:
    - Push request when `ctx_ready`=1 (data `ctxt_char`).
    - Error event when `ptxt_valid_q`=1 and `ctx_ready`=0; increments `err_count`, saturating at all-ones.
    - Cipher error flags may be high during idle gaps, so they are informational only and are never counted directly.
    - `msg_end` → TERM. A `ctx_ready` in the same cycle as `msg_end` is still pushed.
    - `msg_start` while in COLLECT restarts the message: clears status, stays in COLLECT, FIFO contents kept.
  - TERM:
    - Input stream ignored.
    - Pushes TERM_CHAR when not full (or full with a pop in the same cycle); that cycle pulses `msg_done` and goes to IDLE.
    - Otherwise waits in TERM. The terminator is never dropped.
- FIFO:
  - Pop when `out_valid` && `out_ready`.
  - `out_valid` = (`fifo_count` != 0); `out_char` = head entry, registered storage, no input-to-output bypass.
  - Minimum latency from push to `out_valid`: 1 cycle.
  - Push when full with no same-cycle pop: data dropped, `overflow` ← 1.
  - Push when full with a same-cycle pop: accepted, count unchanged.
  - Simultaneous push and pop when empty: pop ignored (`out_valid` is 0), push accepted.
  - Pointers wrap modulo DEPTH.
  - `out_char` and `out_valid` held stable while `out_ready`=0.
- Reset mid-operation: all state is lost, including partial messages and FIFO contents.

Optional Feature:
- Macro: CTXT_COLLECTOR_DROP_CNT_EN.
- Defined:
  - Adds output `drop_count` [ERR_CNT_W-1:0].
  - Counts dropped characters per message; saturating; cleared on `msg_start` and reset.
  - `overflow` = (`drop_count` != 0).
- Undefined: port absent; `overflow` remains a single sticky bit.

Decomposition:
- Package `caesar_pkg`:
  - Character constants: NUL, 'A', 'Z', 'a', 'z'.
  - `coll_state_t` enum: IDLE, COLLECT, TERM.
  - Byte typedef `char_t`.
- One sub-module: `sync_fifo` (parameterised DEPTH/WIDTH, count/full/empty), reusable by an upstream feeder.
- The state machine and counters stay in the top module.

Test Plan:
- `msg_start`, then `ctx_ready` with 'D','E','F' on 3 consecutive cycles, then `msg_end`, `out_ready`=1 → `out_char` sequence 'D','E','F',8'h00; `msg_done` 1 pulse; `err_count`=0.
- In COLLECT, `ptxt_valid_q`=1/`ctx_ready`=0 for 3 cycles, plus 4 idle cycles with error flags high and `ptxt_valid_q`=0 → `err_count`=3. With ERR_CNT_W=2 and 5 events → `err_count`=3 (saturated).
- DEPTH=16, `out_ready`=0, push 17 chars → `fifo_count`=16, `overflow`=1, 17th char absent on drain; with macro, `drop_count`=1.
- FIFO full, `msg_end`, `out_ready`=0 for 5 cycles → stays in TERM, `busy`=1, no `msg_done`. Raise `out_ready` → terminator pushed as the first pop occurs, `msg_done` pulse, IDLE.
- `ctx_ready` pulses in IDLE → `fifo_count` stays 0. Full with simultaneous push and pop → count stays 16, no overflow.
- Assert `rst_n`=0 mid-message with 5 entries queued → `out_valid`, `fifo_count`, `err_count`, `busy` immediately 0, asynchronously.

Source files
------------

// File: rtl/caesar_pkg.sv
// rtl/caesar_pkg.sv - shared character constants and collector state encoding
package caesar_pkg;

    typedef logic [7:0] char_t;

    localparam char_t CHAR_NUL  = 8'h00;
    localparam char_t CHAR_UC_A = 8'h41;
    localparam char_t CHAR_UC_Z = 8'h5A;
    localparam char_t CHAR_LC_A = 8'h61;
    localparam char_t CHAR_LC_Z = 8'h7A;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        TERM    = 2'd2
    } coll_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy count, registered head, no bypass
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_q;
    logic             pop_ok;
    logic             push_ok;

    assign empty     = (count_q == '0);
    assign full      = (count_q == FULL_CNT);
    assign count     = count_q;
    assign head_data = mem[rd_ptr];

    // A pop on an empty FIFO is ignored; a push into a full FIFO only lands if a pop frees a slot.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/ctxt_char_collector.sv
// rtl/ctxt_char_collector.sv - frames cipher output into terminated messages; CTXT_COLLECTOR_DROP_CNT_EN adds drop_count
module ctxt_char_collector
    import caesar_pkg::*;
#(
    parameter int    DEPTH     = 16,
    parameter int    ERR_CNT_W = 8,
    parameter char_t TERM_CHAR = CHAR_NUL
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     msg_start,
    input  logic                     msg_end,
    input  logic                     ptxt_valid_q,
    input  logic                     ctx_ready,
    input  logic [7:0]               ctxt_char,
    input  logic                     err_invalid_key_shift_num,
    input  logic                     err_invalid_ptxt_char,
    output logic                     out_valid,
    output logic [7:0]               out_char,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic [ERR_CNT_W-1:0]     err_count,
`ifdef CTXT_COLLECTOR_DROP_CNT_EN
    output logic [ERR_CNT_W-1:0]     drop_count,
`endif
    output logic                     busy,
    output logic                     msg_done
);
    localparam logic [1:0] ST_IDLE    = IDLE;
    localparam logic [1:0] ST_COLLECT = COLLECT;
    localparam logic [1:0] ST_TERM    = TERM;

    logic [1:0] state;
    logic       push_req;
    char_t      push_data;
    logic       pop;
    logic       fifo_full;
    logic       fifo_empty;
    logic       room;
    logic       drop;
    logic       err_evt;
    logic       clr;
    logic       unused_err_flags;

    // The cipher error flags also toggle during idle gaps, so only the valid/ready mismatch is counted.
    assign unused_err_flags = err_invalid_key_shift_num | err_invalid_ptxt_char;

    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign room      = !fifo_full || pop;
    assign busy      = (state != ST_IDLE);
    assign msg_done  = (state == ST_TERM) && room;
    assign drop      = (state == ST_COLLECT) && ctx_ready && !room;
    assign err_evt   = (state == ST_COLLECT) && ptxt_valid_q && !ctx_ready;
    assign clr       = msg_start && (state != ST_TERM);

    always_comb begin
        push_req  = 1'b0;
        push_data = ctxt_char;
        case (state)
            ST_COLLECT: push_req = ctx_ready;
            ST_TERM: begin
                push_req  = 1'b1;
                push_data = TERM_CHAR;
            end
            default: push_req = 1'b0;
        endcase
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_req),
        .push_data (push_data),
        .pop       (pop),
        .head_data (out_char),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:    if (msg_start) state <= ST_COLLECT;
                ST_COLLECT: if (msg_end)   state <= ST_TERM;
                ST_TERM:    if (room)      state <= ST_IDLE;
                default:    state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (clr) begin
            err_count <= '0;
        end else if (err_evt && (err_count != '1)) begin
            err_count <= err_count + 1'b1;
        end
    end

`ifdef CTXT_COLLECTOR_DROP_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count <= '0;
        end else if (clr) begin
            drop_count <= '0;
        end else if (drop && (drop_count != '1)) begin
            drop_count <= drop_count + 1'b1;
        end
    end

    assign overflow = (drop_count != '0);
`else
    logic overflow_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else if (clr) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end
    end

    assign overflow = overflow_q;
`endif

endmodule

// File: tb/tb_ctxt_char_collector.sv
// tb/tb_ctxt_char_collector.sv - directed self-checking bench for ctxt_char_collector
module tb_ctxt_char_collector;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       msg_start, msg_end, ptxt_valid_q, ctx_ready;
    logic [7:0] ctxt_char;
    logic       err_key, err_char;
    logic       out_ready;
    logic       out_valid;
    logic [7:0] out_char;
    logic [4:0] fifo_count;
    logic       overflow;
    logic [7:0] err_count;
    logic       busy, msg_done;
`ifdef CTXT_COLLECTOR_DROP_CNT_EN
    logic [7:0] drop_count;
    logic [1:0] s_drop_count;
`endif
    logic       s_out_valid, s_overflow, s_busy, s_msg_done;
    logic [7:0] s_out_char;
    logic [4:0] s_fifo_count;
    logic [1:0] s_err_count;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    ctxt_char_collector #(.DEPTH(16), .ERR_CNT_W(8), .TERM_CHAR(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .msg_start(msg_start), .msg_end(msg_end),
        .ptxt_valid_q(ptxt_valid_q), .ctx_ready(ctx_ready), .ctxt_char(ctxt_char),
        .err_invalid_key_shift_num(err_key), .err_invalid_ptxt_char(err_char),
        .out_valid(out_valid), .out_char(out_char), .out_ready(out_ready),
        .fifo_count(fifo_count), .overflow(overflow), .err_count(err_count),
`ifdef CTXT_COLLECTOR_DROP_CNT_EN
        .drop_count(drop_count),
`endif
        .busy(busy), .msg_done(msg_done)
    );

    ctxt_char_collector #(.DEPTH(16), .ERR_CNT_W(2), .TERM_CHAR(8'h00)) dut_sat (
        .clk(clk), .rst_n(rst_n), .msg_start(msg_start), .msg_end(msg_end),
        .ptxt_valid_q(ptxt_valid_q), .ctx_ready(ctx_ready), .ctxt_char(ctxt_char),
        .err_invalid_key_shift_num(err_key), .err_invalid_ptxt_char(err_char),
        .out_valid(s_out_valid), .out_char(s_out_char), .out_ready(out_ready),
        .fifo_count(s_fifo_count), .overflow(s_overflow), .err_count(s_err_count),
`ifdef CTXT_COLLECTOR_DROP_CNT_EN
        .drop_count(s_drop_count),
`endif
        .busy(s_busy), .msg_done(s_msg_done)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drains exactly the queued expectations, then confirms the FIFO is empty.
    task automatic drain_check(input string tag);
        out_ready = 1'b1;
        while (exp_q.size() != 0) begin
            check({tag, "_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_char"}, 32'(out_char), 32'(exp_q.pop_front()));
            tick();
        end
        out_ready = 1'b0;
        check({tag, "_empty"}, 32'(fifo_count), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; msg_start = 0; msg_end = 0; ptxt_valid_q = 0; ctx_ready = 0;
        ctxt_char = 8'h00; err_key = 0; err_char = 0; out_ready = 0;
        #12;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_char", 32'(out_char), 0);
        check("rst_fifo_count", 32'(fifo_count), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_err_count", 32'(err_count), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_msg_done", 32'(msg_done), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Basic three-character message with terminator
        msg_start = 1; tick(); msg_start = 0;
        check("t1_busy", 32'(busy), 1);
        ctx_ready = 1;
        ctxt_char = "D"; tick();
        check("t1_lat1_valid", 32'(out_valid), 1);
        ctxt_char = "E"; tick();
        ctxt_char = "F"; tick();
        ctx_ready = 0; msg_end = 1; tick(); msg_end = 0;
        check("t1_msg_done", 32'(msg_done), 1);
        check("t1_count3", 32'(fifo_count), 3);
        tick();
        check("t1_msg_done_low", 32'(msg_done), 0);
        check("t1_idle", 32'(busy), 0);
        check("t1_count4", 32'(fifo_count), 4);
        check("t1_err", 32'(err_count), 0);
        exp_q = '{8'h44, 8'h45, 8'h46, 8'h00};
        drain_check("t1_drain");

        // Error counting; flags alone never count
        msg_start = 1; tick(); msg_start = 0;
        ptxt_valid_q = 1;
        repeat (3) tick();
        ptxt_valid_q = 0; err_key = 1; err_char = 1;
        repeat (4) tick();
        err_key = 0; err_char = 0;
        check("t2_err3", 32'(err_count), 3);
        ptxt_valid_q = 1;
        repeat (2) tick();
        ptxt_valid_q = 0;
        check("t2_err5", 32'(err_count), 5);
        check("t2_sat", 32'(s_err_count), 3);
        check("t2_count0", 32'(fifo_count), 0);
        msg_end = 1; tick(); msg_end = 0;
        tick();
        exp_q = '{8'h00};
        drain_check("t2_drain");

        // Cipher output ignored while idle
        ctx_ready = 1; ctxt_char = "Z";
        repeat (3) tick();
        ctx_ready = 0;
        check("t3_idle_count", 32'(fifo_count), 0);
        check("t3_idle_valid", 32'(out_valid), 0);

        // Overflow: 17 pushes into 16 entries
        msg_start = 1; tick(); msg_start = 0;
        ctx_ready = 1;
        for (int i = 0; i < 17; i++) begin
            ctxt_char = 8'h61 + 8'(i);
            tick();
        end
        ctx_ready = 0;
        check("t4_count16", 32'(fifo_count), 16);
        check("t4_overflow", 32'(overflow), 1);
`ifdef CTXT_COLLECTOR_DROP_CNT_EN
        check("t4_drop_count", 32'(drop_count), 1);
`endif
        msg_start = 1; tick(); msg_start = 0;
        check("t4_restart_clr", 32'(overflow), 0);
        check("t4_restart_keep", 32'(fifo_count), 16);
        // Full with simultaneous push and pop: accepted, no drop
        ctx_ready = 1; ctxt_char = "X"; out_ready = 1;
        tick();
        ctx_ready = 0; out_ready = 0;
        check("t5_full_pushpop_count", 32'(fifo_count), 16);
        check("t5_full_pushpop_ovf", 32'(overflow), 0);
        check("t5_head", 32'(out_char), 32'h62);

        // Terminator waits while full
        msg_end = 1; tick(); msg_end = 0;
        for (int i = 0; i < 5; i++) begin
            check("t6_wait_busy", 32'(busy), 1);
            check("t6_wait_done", 32'(msg_done), 0);
            check("t6_wait_count", 32'(fifo_count), 16);
            tick();
        end
        out_ready = 1;
        #1;
        check("t6_done_pulse", 32'(msg_done), 1);
        tick();
        out_ready = 0;
        check("t6_idle", 32'(busy), 0);
        check("t6_done_low", 32'(msg_done), 0);
        check("t6_count", 32'(fifo_count), 16);
        for (int i = 2; i < 16; i++) exp_q.push_back(8'h61 + 8'(i));
        exp_q.push_back(8'h58);
        exp_q.push_back(8'h00);
        drain_check("t6_drain");

        // Asynchronous reset mid-message
        msg_start = 1; tick(); msg_start = 0;
        ctx_ready = 1;
        for (int i = 0; i < 5; i++) begin
            ctxt_char = 8'h41 + 8'(i);
            tick();
        end
        ctx_ready = 0; ptxt_valid_q = 1; tick(); ptxt_valid_q = 0;
        check("t7_pre_count", 32'(fifo_count), 5);
        check("t7_pre_err", 32'(err_count), 1);
        rst_n = 1'b0;
        #1;
        check("t7_rst_valid", 32'(out_valid), 0);
        check("t7_rst_count", 32'(fifo_count), 0);
        check("t7_rst_err", 32'(err_count), 0);
        check("t7_rst_busy", 32'(busy), 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("t7_post_busy", 32'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
